key_event_arb: RTL and testbench

- Collects single-cycle press pulses from N_KEYS debounced key channels and serialises them into one ordered event stream (key index) for the downstream command/UI FSM.
- Each key has a pending latch. A round-robin arbiter picks one pending key per cycle into a small event FIFO. Output uses a valid/ready handshake.
- Sits directly after the per-key debounce/edge-pulse instances. It is the single point through which all keypad input reaches control logic.

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_evt_fifo.sv | 52 +++++
 rtl/key_event_arb.sv | 112 +++++++++++
 tb/tb_key_event_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared key-path definitions: default keypad geometry and the key index width/type
// used by the event arbiter and by downstream UI decode.
package key_pkg;

   localparam int DEF_N_KEYS     = 4;
   localparam int DEF_FIFO_DEPTH = 4;

   // Ceiling log2 for index widths; never below 1 so a 1-bit index always exists.
   function automatic int key_clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   localparam int KEY_IDX_W = key_clog2(DEF_N_KEYS);

   typedef logic [KEY_IDX_W-1:0] key_idx_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Generic synchronous FIFO with pointer/count bookkeeping; head data reads as zero when empty.
module key_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push, do_pop;

   assign full     = (count_reg == CW'(DEPTH));
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/key_event_arb.sv
// Serialises per-key press pulses into an ordered key-index event stream via pending
// latches, a round-robin arbiter and an event FIFO. Optional drop counter: KEY_EVENT_ARB_DROP_CNT_EN.
module key_event_arb
   import key_pkg::*;
#(
   parameter int N_KEYS     = DEF_N_KEYS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int IDX_W     = key_clog2(N_KEYS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_pulse,
   output logic              evt_valid,
   output logic [IDX_W-1:0]  evt_key,
   input  logic              evt_ready,
   output logic [N_KEYS-1:0] pending,
   output logic              ovf,
   input  logic              ovf_clr
`ifdef KEY_EVENT_ARB_DROP_CNT_EN
   ,
   output logic [7:0]        drop_cnt
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [N_KEYS-1:0] pending_reg, pending_next, gnt_vec, loss_vec;
   logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next, winner;
   logic [IDX_W:0]    cand;
   logic              found, grant, ovf_reg;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;

   // First pending key at or after rr_ptr, wrapping modulo N_KEYS.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(N_KEYS)) cand = cand - (IDX_W+1)'(N_KEYS);
         if (!found && pending_reg[cand[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[IDX_W-1:0];
         end
      end
   end

   assign grant       = found && !fifo_full;
   assign rr_ptr_next = (winner == IDX_W'(N_KEYS - 1)) ? '0 : winner + 1'b1;

   // A pulse arriving in its own key's grant cycle is a fresh event, not a loss.
   for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      assign gnt_vec[gi]      = grant && (winner == IDX_W'(gi));
      assign loss_vec[gi]     = key_pulse[gi] && pending_reg[gi] && !gnt_vec[gi];
      assign pending_next[gi] = key_pulse[gi] || (pending_reg[gi] && !gnt_vec[gi]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg <= '0;
         rr_ptr_reg  <= '0;
         ovf_reg     <= 1'b0;
      end else begin
         pending_reg <= pending_next;
         if (grant) rr_ptr_reg <= rr_ptr_next;
         if (|loss_vec)    ovf_reg <= 1'b1;
         else if (ovf_clr) ovf_reg <= 1'b0;
      end
   end

   key_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (IDX_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (grant),
      .push_data (winner),
      .full      (fifo_full),
      .pop       (evt_ready && !fifo_empty),
      .pop_data  (evt_key),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign evt_valid = (fifo_count != '0);
   assign pending   = pending_reg;
   assign ovf       = ovf_reg;

`ifdef KEY_EVENT_ARB_DROP_CNT_EN
   logic [7:0] drop_cnt_reg, drop_cnt_next, drop_base;
   logic [4:0] loss_num;
   logic [8:0] drop_sum;

   always_comb begin
      loss_num = '0;
      for (int i = 0; i < N_KEYS; i++) loss_num = loss_num + 5'(loss_vec[i]);
      drop_base     = ovf_clr ? 8'd0 : drop_cnt_reg;
      drop_sum      = {1'b0, drop_base} + 9'(loss_num);
      drop_cnt_next = drop_sum[8] ? 8'd255 : drop_sum[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_reg <= '0;
      else        drop_cnt_reg <= drop_cnt_next;
   end

   assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_key_event_arb.sv
// Directed self-checking bench for key_event_arb (N_KEYS=4, FIFO_DEPTH=4).
module tb_key_event_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key_pulse;
   logic       evt_valid;
   logic [1:0] evt_key;
   logic       evt_ready;
   logic [3:0] pending;
   logic       ovf;
   logic       ovf_clr;
`ifdef KEY_EVENT_ARB_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   key_event_arb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_pulse (key_pulse),
      .evt_valid (evt_valid),
      .evt_key   (evt_key),
      .evt_ready (evt_ready),
      .pending   (pending),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
`ifdef KEY_EVENT_ARB_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n     = 1'b0;
      key_pulse = '0;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      do_reset();
      tests++;
      if ({evt_valid, evt_key, pending, ovf} !== 8'b0) begin
         failed++;
         $display("FAIL reset: valid=%b key=%0d pending=%b ovf=%b, want all 0", evt_valid, evt_key, pending, ovf);
      end
      $display("[TB] reset checked");
   endtask

   task automatic test_single_press;
      do_reset();
      evt_ready = 1'b1;
      key_pulse = 4'b0100;
      tick();
      key_pulse = '0;
      tests++;
      if (pending !== 4'b0100 || evt_valid !== 1'b0) begin
         failed++;
         $display("FAIL single_lat1: pending=%b valid=%b, want 0100/0", pending, evt_valid);
      end
      tick();
      tests++;
      if (evt_valid !== 1'b1 || evt_key !== 2'd2 || ovf !== 1'b0) begin
         failed++;
         $display("FAIL single_evt: valid=%b key=%0d ovf=%b, want 1/2/0", evt_valid, evt_key, ovf);
      end
      tick();
      tests++;
      if (evt_valid !== 1'b0) begin
         failed++;
         $display("FAIL single_once: valid=%b, want 0", evt_valid);
      end
      $display("[TB] single press key 2 done");
   endtask

   task automatic test_simultaneous;
      logic [1:0] exp_keys [3];
      exp_keys = '{2'd0, 2'd1, 2'd3};
      do_reset();
      evt_ready = 1'b1;
      key_pulse = 4'b1011;
      tick();
      key_pulse = '0;
      tick();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (evt_valid !== 1'b1 || evt_key !== exp_keys[i]) begin
            failed++;
            $display("FAIL simul_evt%0d: valid=%b key=%0d, want 1/%0d", i, evt_valid, evt_key, exp_keys[i]);
         end
         $display("[TB] simultaneous event %0d key %0d", i, evt_key);
         tick();
      end
      tests++;
      if (evt_valid !== 1'b0) begin
         failed++;
         $display("FAIL simul_drain: valid=%b, want 0", evt_valid);
      end
      // rr_ptr should be back at 0: keys 3 and 0 together must yield 0 first.
      key_pulse = 4'b1001;
      tick();
      key_pulse = '0;
      tick();
      tests++;
      if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
         failed++;
         $display("FAIL simul_rrptr: valid=%b key=%0d, want 1/0", evt_valid, evt_key);
      end
      tick();
      tests++;
      if (evt_valid !== 1'b1 || evt_key !== 2'd3) begin
         failed++;
         $display("FAIL simul_rrptr2: valid=%b key=%0d, want 1/3", evt_valid, evt_key);
      end
      tick();
   endtask

   task automatic test_round_robin;
      do_reset();
      evt_ready = 1'b1;
      key_pulse = 4'b0010;
      tick();
      key_pulse = '0;
      tick();
      tick();
      key_pulse = 4'b0101;
      tick();
      key_pulse = '0;
      tick();
      tests++;
      if (evt_valid !== 1'b1 || evt_key !== 2'd2) begin
         failed++;
         $display("FAIL rr_first: valid=%b key=%0d, want 1/2", evt_valid, evt_key);
      end
      tick();
      tests++;
      if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
         failed++;
         $display("FAIL rr_second: valid=%b key=%0d, want 1/0", evt_valid, evt_key);
      end
      tick();
      $display("[TB] round-robin after key 1 done");
   endtask

   task automatic test_back_pressure;
      logic [1:0] exp_keys [5];
      exp_keys = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      key_pulse = 4'b1111;
      tick();
      key_pulse = '0;
      repeat (4) tick();
      tests++;
      if (pending !== 4'b0000 || evt_valid !== 1'b1 || evt_key !== 2'd0) begin
         failed++;
         $display("FAIL bp_fill: pending=%b valid=%b key=%0d, want 0000/1/0", pending, evt_valid, evt_key);
      end
      key_pulse = 4'b0001;
      tick();
      key_pulse = '0;
      tests++;
      if (pending !== 4'b0001 || ovf !== 1'b0) begin
         failed++;
         $display("FAIL bp_pend: pending=%b ovf=%b, want 0001/0", pending, ovf);
      end
      key_pulse = 4'b0001;
      tick();
      key_pulse = '0;
      tests++;
      if (pending !== 4'b0001 || ovf !== 1'b1 || evt_key !== 2'd0) begin
         failed++;
         $display("FAIL bp_ovf: pending=%b ovf=%b key=%0d, want 0001/1/0", pending, ovf, evt_key);
      end
`ifdef KEY_EVENT_ARB_DROP_CNT_EN
      tests++;
      if (drop_cnt !== 8'd1) begin
         failed++;
         $display("FAIL bp_drop: drop_cnt=%0d, want 1", drop_cnt);
      end
`endif
      evt_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (evt_valid !== 1'b1 || evt_key !== exp_keys[i]) begin
            failed++;
            $display("FAIL bp_drain%0d: valid=%b key=%0d, want 1/%0d", i, evt_valid, evt_key, exp_keys[i]);
         end
         $display("[TB] back-pressure drain %0d key %0d", i, evt_key);
         tick();
      end
      tests++;
      if (evt_valid !== 1'b0) begin
         failed++;
         $display("FAIL bp_empty: valid=%b, want 0", evt_valid);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      tests++;
      if (ovf !== 1'b0) begin
         failed++;
         $display("FAIL ovf_clr: ovf=%b, want 0", ovf);
      end
`ifdef KEY_EVENT_ARB_DROP_CNT_EN
      tests++;
      if (drop_cnt !== 8'd0) begin
         failed++;
         $display("FAIL drop_clr: drop_cnt=%0d, want 0", drop_cnt);
      end
`endif
   endtask

   task automatic test_pulse_during_grant;
      do_reset();
      evt_ready = 1'b1;
      key_pulse = 4'b0010;
      tick();
      // key 1 is pending and wins this cycle; pulse it again now.
      key_pulse = 4'b0010;
      tick();
      key_pulse = '0;
      tests++;
      if (pending !== 4'b0010 || evt_valid !== 1'b1 || evt_key !== 2'd1 || ovf !== 1'b0) begin
         failed++;
         $display("FAIL grant_pulse1: pending=%b valid=%b key=%0d ovf=%b, want 0010/1/1/0", pending, evt_valid, evt_key, ovf);
      end
      tick();
      tests++;
      if (evt_valid !== 1'b1 || evt_key !== 2'd1 || ovf !== 1'b0) begin
         failed++;
         $display("FAIL grant_pulse2: valid=%b key=%0d ovf=%b, want 1/1/0", evt_valid, evt_key, ovf);
      end
      tick();
      tests++;
      if (evt_valid !== 1'b0) begin
         failed++;
         $display("FAIL grant_pulse_end: valid=%b, want 0", evt_valid);
      end
      $display("[TB] pulse during grant done");
   endtask

   task automatic test_async_reset;
      do_reset();
      key_pulse = 4'b0111;
      tick();
      key_pulse = 4'b0100;
      tick();
      key_pulse = '0;
      tick();
      key_pulse = 4'b1000;
      tick();
      key_pulse = '0;
      tests++;
      if (ovf !== 1'b1 || pending !== 4'b1000 || evt_valid !== 1'b1) begin
         failed++;
         $display("FAIL areset_pre: ovf=%b pending=%b valid=%b, want 1/1000/1", ovf, pending, evt_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (evt_valid !== 1'b0 || pending !== 4'b0000 || ovf !== 1'b0) begin
         failed++;
         $display("FAIL areset_now: valid=%b pending=%b ovf=%b, want 0/0000/0", evt_valid, pending, ovf);
      end
      #1;
      rst_n     = 1'b1;
      evt_ready = 1'b1;
      repeat (4) begin
         tick();
         tests++;
         if (evt_valid !== 1'b0) begin
            failed++;
            $display("FAIL areset_quiet: valid=%b, want 0", evt_valid);
         end
      end
      key_pulse = 4'b1000;
      tick();
      key_pulse = '0;
      tick();
      tests++;
      if (evt_valid !== 1'b1 || evt_key !== 2'd3) begin
         failed++;
         $display("FAIL areset_new: valid=%b key=%0d, want 1/3", evt_valid, evt_key);
      end
      tick();
      $display("[TB] async reset mid-stream done");
   endtask

   initial begin
      rst_n     = 1'b0;
      key_pulse = '0;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      test_reset();
      test_single_press();
      test_simultaneous();
      test_round_robin();
      test_back_pressure();
      test_pulse_during_grant();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
